// File: rtl/rv32_decode_stage_pkg.sv
// Shared decode/ALU header: ALU op codes, RV32I opcodes, issue classes and
// the registered issue bundle layout.
package rv32_decode_stage_pkg;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,  ALU_SUB  = 5'd1,  ALU_SLL  = 5'd2,  ALU_SLT = 5'd3,
    ALU_SLTU = 5'd4,  ALU_XOR  = 5'd5,  ALU_SRL  = 5'd6,  ALU_SRA = 5'd7,
    ALU_OR   = 5'd8,  ALU_AND  = 5'd9,  ALU_EQ   = 5'd10, ALU_NEQ = 5'd11,
    ALU_LT   = 5'd12, ALU_GE   = 5'd13, ALU_LTU  = 5'd14, ALU_GEU = 5'd15
  } alu_op_e;

  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_LOAD   = 3'd1,
    CLS_STORE  = 3'd2,
    CLS_BRANCH = 3'd3,
    CLS_JAL    = 3'd4,
    CLS_JALR   = 3'd5
  } inst_class_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [31:0] i;
    logic [31:0] s;
    logic [31:0] b;
    logic [31:0] u;
    logic [31:0] j;
  } imm_t;

  typedef struct packed {
    alu_op_e     op;
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        we;
    inst_class_e cls;
    logic        illegal;
  } issue_t;

  // funct3 -> ALU op for OP / OP-IMM; alt selects SUB/SRA
  function automatic alu_op_e alu_op_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // funct3 -> compare op for BRANCH (010/011 are rejected by the caller)
  function automatic alu_op_e branch_op_from_f3(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_EQ;
      3'b001:  return ALU_NEQ;
      3'b100:  return ALU_LT;
      3'b101:  return ALU_GE;
      3'b110:  return ALU_LTU;
      default: return ALU_GEU;
    endcase
  endfunction

endpackage

// File: rtl/rv32_decode_stage_if.sv
// Fetch-in / regfile / issue-out / writeback bundle of the decode stage.
// master = decode stage, slave = surrounding pipeline.
interface rv32_decode_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_alu_op;
  logic [31:0] out_lhs;
  logic [31:0] out_rhs;
  logic [31:0] out_imm;
  logic [31:0] out_pc;
  logic [4:0]  out_rd;
  logic        out_we;
  logic [2:0]  out_class;
  logic        out_illegal;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;

  modport master (
    input  in_valid, in_pc, in_inst, rs1_data, rs2_data, out_ready,
           wb_valid, wb_rd, flush,
    output in_ready, rs1_addr, rs2_addr, out_valid, out_alu_op, out_lhs,
           out_rhs, out_imm, out_pc, out_rd, out_we, out_class, out_illegal
  );

  modport slave (
    output in_valid, in_pc, in_inst, rs1_data, rs2_data, out_ready,
           wb_valid, wb_rd, flush,
    input  in_ready, rs1_addr, rs2_addr, out_valid, out_alu_op, out_lhs,
           out_rhs, out_imm, out_pc, out_rd, out_we, out_class, out_illegal
  );
endinterface

// File: rtl/rv32_imm_gen.sv
// RV32I immediate extraction; opcode bits are not needed so only [31:7] enter.
module rv32_imm_gen
  import rv32_decode_stage_pkg::*;
(
  input  logic [31:7] inst,
  output imm_t        imm
);
  assign imm.i = {{20{inst[31]}}, inst[31:20]};
  assign imm.s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm.b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm.u = {inst[31:12], 12'd0};
  assign imm.j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
endmodule

// File: rtl/rv32_decode_stage.sv
// RV32I decode/issue stage: decodes the fetch bundle, reads operands,
// stalls on RAW hazards via a busy-bit scoreboard and registers the issue bundle.
module rv32_decode_stage
  import rv32_decode_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input logic             CLK,
  input logic             RST_X,
  rv32_decode_stage_if.master bus
);

  logic [6:0]      opc, f7;
  logic [2:0]      f3;
  logic [4:0]      rd, rs1, rs2;
  logic [XLEN-1:0] rs1_v, rs2_v;
  imm_t            imm;
  issue_t          dec, q;
  logic            out_valid_q;
  logic            legal, wr, uses_rs1, uses_rs2, is_shift;
  logic [NREG-1:0] busy, busy_nxt;
  logic            hazard, load_en, in_ready, fire;

  assign opc = bus.in_inst[6:0];
  assign rd  = bus.in_inst[11:7];
  assign f3  = bus.in_inst[14:12];
  assign rs1 = bus.in_inst[19:15];
  assign rs2 = bus.in_inst[24:20];
  assign f7  = bus.in_inst[31:25];

  assign bus.rs1_addr = rs1;
  assign bus.rs2_addr = rs2;

  // x0 is hard-wired to zero whatever the regfile returns
  assign rs1_v = (rs1 == 5'd0) ? '0 : bus.rs1_data;
  assign rs2_v = (rs2 == 5'd0) ? '0 : bus.rs2_data;

  rv32_imm_gen u_imm_gen (
    .inst (bus.in_inst[31:7]),
    .imm  (imm)
  );

  // Decode the fetch bundle into the issue bundle and source-use flags
  always_comb begin
    dec      = '0;
    dec.op   = ALU_ADD;
    dec.cls  = CLS_ALU;
    dec.pc   = bus.in_pc;
    dec.rd   = rd;
    legal    = 1'b0;
    wr       = 1'b0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    is_shift = (f3 == 3'b001) || (f3 == 3'b101);
    case (opc)
      OPC_OP: begin
        if (f7 == F7_BASE || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101))) begin
          legal = 1'b1; wr = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
          dec.op  = alu_op_from_f3(f3, f7[5]);
          dec.lhs = rs1_v;
          dec.rhs = rs2_v;
        end
      end
      OPC_OP_IMM: begin
        // shifts constrain funct7; other ops use the whole field as immediate
        if (!is_shift || f7 == F7_BASE || (f3 == 3'b101 && f7 == F7_ALT)) begin
          legal = 1'b1; wr = 1'b1; uses_rs1 = 1'b1;
          dec.op  = alu_op_from_f3(f3, (f3 == 3'b101) & f7[5]);
          dec.lhs = rs1_v;
          dec.rhs = is_shift ? {{(XLEN-5){1'b0}}, rs2} : imm.i;
          dec.imm = imm.i;
        end
      end
      OPC_LUI: begin
        legal = 1'b1; wr = 1'b1;
        dec.rhs = imm.u;
        dec.imm = imm.u;
      end
      OPC_AUIPC: begin
        legal = 1'b1; wr = 1'b1;
        dec.lhs = bus.in_pc;
        dec.rhs = imm.u;
        dec.imm = imm.u;
      end
      OPC_LOAD: begin
        if (f3 != 3'b011 && f3 != 3'b110 && f3 != 3'b111) begin
          legal = 1'b1; wr = 1'b1; uses_rs1 = 1'b1;
          dec.cls = CLS_LOAD;
          dec.lhs = rs1_v;
          dec.rhs = imm.i;
          dec.imm = imm.i;
        end
      end
      OPC_STORE: begin
        if (f3 <= 3'b010) begin
          legal = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
          dec.cls = CLS_STORE;
          dec.lhs = rs1_v;
          dec.rhs = imm.s;
          dec.imm = imm.s;
        end
      end
      OPC_BRANCH: begin
        if (f3 != 3'b010 && f3 != 3'b011) begin
          legal = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
          dec.cls = CLS_BRANCH;
          dec.op  = branch_op_from_f3(f3);
          dec.lhs = rs1_v;
          dec.rhs = rs2_v;
          dec.imm = imm.b;
        end
      end
      OPC_JAL: begin
        legal = 1'b1; wr = 1'b1;
        dec.cls = CLS_JAL;
        dec.lhs = bus.in_pc;
        dec.rhs = 32'd4;
        dec.imm = imm.j;
      end
      OPC_JALR: begin
        if (f3 == 3'b000) begin
          legal = 1'b1; wr = 1'b1; uses_rs1 = 1'b1;
          dec.cls = CLS_JALR;
          dec.lhs = bus.in_pc;
          dec.rhs = 32'd4;
          dec.imm = imm.i;
        end
      end
      default: ;
    endcase
    // undecodable words still issue, as an inert ADD 0,0 flagged illegal
    if (!legal) begin
      dec.op      = ALU_ADD;
      dec.cls     = CLS_ALU;
      dec.lhs     = '0;
      dec.rhs     = '0;
      dec.imm     = '0;
      dec.illegal = 1'b1;
      uses_rs1    = 1'b0;
      uses_rs2    = 1'b0;
    end
    dec.we = wr & legal & (rd != 5'd0);
  end

  assign hazard   = (busy[rs1] & uses_rs1) | (busy[rs2] & uses_rs2);
  assign load_en  = !out_valid_q | bus.out_ready;
  assign in_ready = load_en & !hazard & !bus.flush & !RST_X;
  assign fire     = bus.in_valid & in_ready;
  assign bus.in_ready = in_ready;

  // Scoreboard next state: writeback clears, issue sets (set wins on same reg)
  always_comb begin
    busy_nxt = busy;
    if (bus.wb_valid) busy_nxt[bus.wb_rd] = 1'b0;
    if (fire && dec.we) busy_nxt[rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard register; flush drops every pending write, squashed one included
  always_ff @(posedge CLK) begin
    if (RST_X)          busy <= '0;
    else if (bus.flush) busy <= '0;
    else                busy <= busy_nxt;
  end

  // Issue register: capture on fire, drain when consumed, hold under backpressure
  always_ff @(posedge CLK) begin
    if (RST_X) begin
      out_valid_q <= 1'b0;
      q           <= '0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (load_en) begin
      out_valid_q <= fire;
      if (fire) q <= dec;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_alu_op  = q.op;
  assign bus.out_lhs     = q.lhs;
  assign bus.out_rhs     = q.rhs;
  assign bus.out_imm     = q.imm;
  assign bus.out_pc      = q.pc;
  assign bus.out_rd      = q.rd;
  assign bus.out_we      = q.we;
  assign bus.out_class   = q.cls;
  assign bus.out_illegal = q.illegal;

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Bench for rv32_decode_stage: directed RV32I vectors, an ISA-level reference
// model checked every cycle, plus hand-computed expectations.
module tb_rv32_decode_stage;

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] lhs, rhs, imm, pc;
    logic [4:0]  rd;
    logic        we;
    logic [2:0]  cls;
    logic        ill, u1, u2;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rv32_decode_stage_if bus();
  rv32_decode_stage dut (.CLK(clk), .RST_X(rst), .bus(bus.master));

  logic [31:0] rf [32];
  assign bus.rs1_data = rf[bus.rs1_addr];
  assign bus.rs2_data = rf[bus.rs2_addr];

  int n_chk = 0, n_fail = 0;
  bit done = 0;

  // reference state
  logic        m_valid = 1'b0;
  exp_t        m_q = '0;
  logic [31:0] m_busy = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ISA-level decode: what the issue bundle must be for this word
  function automatic exp_t model_dec(input logic [31:0] pc, input logic [31:0] inst);
    exp_t e;
    logic ok, wr, sh;
    logic [31:0] a, b, iI, iS, iB, iU, iJ;
    logic [2:0] f3;
    logic [6:0] f7;
    int otab[8];
    int btab[8];
    otab = '{0, 2, 3, 4, 5, 6, 8, 9};
    btab = '{10, 11, -1, -1, 12, 13, 14, 15};
    f3 = inst[14:12];
    f7 = inst[31:25];
    a  = (inst[19:15] == 5'd0) ? 32'd0 : rf[inst[19:15]];
    b  = (inst[24:20] == 5'd0) ? 32'd0 : rf[inst[24:20]];
    iI = {{20{inst[31]}}, inst[31:20]};
    iS = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    iB = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    iU = {inst[31:12], 12'd0};
    iJ = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    e = '0; e.pc = pc; e.rd = inst[11:7]; ok = 0; wr = 0;
    sh = (f3 == 3'd1) || (f3 == 3'd5);
    case (inst[6:0])
      7'b0110011: if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
        ok = 1; wr = 1; e.u1 = 1; e.u2 = 1;
        e.op = 5'(otab[f3] + (f7[5] ? 1 : 0)); e.lhs = a; e.rhs = b;
      end
      7'b0010011: if (!sh || f7 == 7'h00 || (f3 == 3'd5 && f7 == 7'h20)) begin
        ok = 1; wr = 1; e.u1 = 1;
        e.op = 5'(otab[f3] + ((f3 == 3'd5 && inst[30]) ? 1 : 0));
        e.lhs = a; e.rhs = sh ? {27'd0, inst[24:20]} : iI; e.imm = iI;
      end
      7'b0110111: begin ok = 1; wr = 1; e.rhs = iU; e.imm = iU; end
      7'b0010111: begin ok = 1; wr = 1; e.lhs = pc; e.rhs = iU; e.imm = iU; end
      7'b0000011: if (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) begin
        ok = 1; wr = 1; e.u1 = 1; e.cls = 3'd1; e.lhs = a; e.rhs = iI; e.imm = iI;
      end
      7'b0100011: if (f3 <= 3'd2) begin
        ok = 1; e.u1 = 1; e.u2 = 1; e.cls = 3'd2; e.lhs = a; e.rhs = iS; e.imm = iS;
      end
      7'b1100011: if (btab[f3] >= 0) begin
        ok = 1; e.u1 = 1; e.u2 = 1; e.cls = 3'd3; e.op = 5'(btab[f3]);
        e.lhs = a; e.rhs = b; e.imm = iB;
      end
      7'b1101111: begin ok = 1; wr = 1; e.cls = 3'd4; e.lhs = pc; e.rhs = 4; e.imm = iJ; end
      7'b1100111: if (f3 == 3'd0) begin
        ok = 1; wr = 1; e.u1 = 1; e.cls = 3'd5; e.lhs = pc; e.rhs = 4; e.imm = iI;
      end
      default: ;
    endcase
    if (!ok) begin
      e.op = 0; e.lhs = 0; e.rhs = 0; e.imm = 0; e.cls = 0; e.ill = 1; e.u1 = 0; e.u2 = 0;
    end
    e.we = wr && (inst[11:7] != 5'd0);
    return e;
  endfunction

  function automatic logic m_rdy();
    exp_t e;
    logic haz;
    e   = model_dec(bus.in_pc, bus.in_inst);
    haz = (e.u1 && m_busy[bus.in_inst[19:15]]) || (e.u2 && m_busy[bus.in_inst[24:20]]);
    return (!m_valid || bus.out_ready) && !haz && !bus.flush && !rst;
  endfunction

  // reference model state update
  always @(posedge clk) begin
    logic fire;
    exp_t e;
    logic [31:0] nb;
    if (rst) begin
      m_valid = 0; m_q = '0; m_busy = '0;
    end else begin
      fire = bus.in_valid && m_rdy();
      e    = model_dec(bus.in_pc, bus.in_inst);
      nb   = m_busy;
      if (bus.flush) begin
        nb = '0; m_valid = 0;
      end else begin
        if (bus.wb_valid) nb[bus.wb_rd] = 1'b0;
        if (fire && e.we) nb[e.rd] = 1'b1;
        if (fire) begin m_valid = 1; m_q = e; end
        else if (!m_valid || bus.out_ready) m_valid = 0;
      end
      m_busy = nb;
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (!done) begin
      chk("in_ready",  32'(bus.in_ready),    32'(m_rdy()));
      chk("rs1_addr",  32'(bus.rs1_addr),    32'(bus.in_inst[19:15]));
      chk("rs2_addr",  32'(bus.rs2_addr),    32'(bus.in_inst[24:20]));
      chk("out_valid", 32'(bus.out_valid),   32'(m_valid));
      chk("alu_op",    32'(bus.out_alu_op),  32'(m_q.op));
      chk("lhs",       bus.out_lhs,          m_q.lhs);
      chk("rhs",       bus.out_rhs,          m_q.rhs);
      chk("imm",       bus.out_imm,          m_q.imm);
      chk("pc",        bus.out_pc,           m_q.pc);
      chk("rd",        32'(bus.out_rd),      32'(m_q.rd));
      chk("we",        32'(bus.out_we),      32'(m_q.we));
      chk("class",     32'(bus.out_class),   32'(m_q.cls));
      chk("illegal",   32'(bus.out_illegal), 32'(m_q.ill));
    end
  end

  task automatic sync();
    @(posedge clk); #1;
  endtask

  // present a bundle and hold it until accepted (bounded); n = stall cycles
  task automatic send(input logic [31:0] pc, input logic [31:0] inst, input int max, output int n);
    bus.in_valid = 1; bus.in_pc = pc; bus.in_inst = inst;
    n = 0;
    @(negedge clk);
    while (!m_rdy() && n < max) begin @(negedge clk); n++; end
    if (n >= max) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: inst %h not accepted after %0d cycles", inst, n);
    end
    @(posedge clk); #1;
    bus.in_valid = 0;
  endtask

  task automatic wb_pulse(input logic [4:0] r);
    bus.wb_valid = 1; bus.wb_rd = r;
    @(posedge clk); #1;
    bus.wb_valid = 0;
  endtask

  logic [31:0] vec_inst [10];
  int n;

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
    rf[0] = 32'hDEAD_BEEF; rf[1] = 9; rf[2] = 4;
    bus.in_valid = 0; bus.in_pc = 0; bus.in_inst = 0; bus.out_ready = 1;
    bus.wb_valid = 0; bus.wb_rd = 0; bus.flush = 0;
    vec_inst = '{32'h00001317, 32'h4030D393, 32'h0020A623, 32'hFFC0A403, 32'h00008067,
                 32'h010005EF, 32'hFFFFFFFF, 32'h000004B3, 32'h02208033, 32'h0020A063};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_lhs", bus.out_lhs, 0);
    sync(); rst = 0;

    // ADDI x1,x0,5
    send(32'h100, 32'h00500093, 10, n);
    @(negedge clk);
    chk("addi_valid", 32'(bus.out_valid), 1);
    chk("addi_op", 32'(bus.out_alu_op), 0);
    chk("addi_lhs", bus.out_lhs, 0);
    chk("addi_rhs", bus.out_rhs, 5);
    chk("addi_rd", 32'(bus.out_rd), 1);
    chk("addi_we", 32'(bus.out_we), 1);
    chk("addi_pc", bus.out_pc, 32'h100);

    // ADD x2,x1,x1 stalls on x1 until the cycle after its writeback
    sync();
    fork
      send(32'h104, 32'h00108133, 20, n);
      begin repeat (3) @(posedge clk); #1 wb_pulse(5'd1); end
    join
    chk("raw_stall_cycles", n, 4);
    @(negedge clk);
    chk("add_lhs", bus.out_lhs, 9);
    chk("add_rhs", bus.out_rhs, 9);

    // SUB x3,x1,x2 once x2 is retired
    sync(); wb_pulse(5'd2);
    send(32'h108, 32'h402081B3, 10, n);
    @(negedge clk);
    chk("sub_op", 32'(bus.out_alu_op), 1);
    chk("sub_lhs", bus.out_lhs, 9);
    chk("sub_rhs", bus.out_rhs, 4);
    chk("sub_rd", 32'(bus.out_rd), 3);

    // BEQ x1,x2,+8
    sync(); send(32'h10C, 32'h00208463, 10, n);
    @(negedge clk);
    chk("beq_op", 32'(bus.out_alu_op), 10);
    chk("beq_imm", bus.out_imm, 8);
    chk("beq_we", 32'(bus.out_we), 0);
    chk("beq_class", 32'(bus.out_class), 3);

    // LUI x5,0x12345
    sync(); send(32'h110, 32'h123452B7, 10, n);
    @(negedge clk);
    chk("lui_lhs", bus.out_lhs, 0);
    chk("lui_rhs", bus.out_rhs, 32'h12345000);
    chk("lui_rd", 32'(bus.out_rd), 5);

    // AUIPC, SRAI, SW, LW, JALR, JAL, illegal, x0 reads, MUL, bad branch
    for (int i = 0; i < 10; i++) send(32'h200 + 32'(4 * i), vec_inst[i], 10, n);
    @(negedge clk);
    chk("badbr_illegal", 32'(bus.out_illegal), 1);
    chk("badbr_we", 32'(bus.out_we), 0);

    // backpressure: held bundle stays put, in_ready low
    sync(); bus.out_ready = 0;
    send(32'h300, 32'h00700613, 10, n);
    bus.in_valid = 1; bus.in_pc = 32'h304; bus.in_inst = 32'h00100693;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(bus.in_ready), 0);
      chk("bp_rd", 32'(bus.out_rd), 12);
      chk("bp_rhs", bus.out_rhs, 7);
    end
    sync(); bus.out_ready = 1;
    @(negedge clk);
    chk("bp_release_ready", 32'(bus.in_ready), 1);
    @(posedge clk); #1 bus.in_valid = 0; bus.out_ready = 0;
    @(negedge clk);
    chk("bp_next_rd", 32'(bus.out_rd), 13);

    // flush squashes the held bundle and the scoreboard
    sync(); bus.flush = 1;
    @(negedge clk);
    chk("flush_in_ready", 32'(bus.in_ready), 0);
    sync(); bus.flush = 0; bus.out_ready = 1;
    @(negedge clk);
    chk("flush_out_valid", 32'(bus.out_valid), 0);
    sync(); send(32'h400, 32'h00D607B3, 3, n);
    chk("flush_busy_clear", n, 0);

    // same-edge set and clear of x16: set wins
    sync(); bus.wb_valid = 1; bus.wb_rd = 5'd16;
    send(32'h500, 32'h00100813, 5, n);
    bus.wb_valid = 0;
    fork
      send(32'h504, 32'h000808B3, 20, n);
      begin repeat (3) @(posedge clk); #1 wb_pulse(5'd16); end
    join
    chk("set_wins_stall", n, 4);

    // reset mid-operation discards bundle and scoreboard
    sync(); rst = 1;
    @(negedge clk);
    chk("mid_rst_ready", 32'(bus.in_ready), 0);
    sync(); rst = 0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_rd", 32'(bus.out_rd), 0);
    sync(); send(32'h600, 32'h01088933, 3, n);
    chk("rst_busy_clear", n, 0);
    @(negedge clk);
    chk("post_rst_lhs", bus.out_lhs, 32'h1011);
    chk("post_rst_rhs", bus.out_rhs, 32'h1010);

    sync(); sync();
    done = 1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
